// File: rtl/cfg_alu_if.sv
// Operand/opcode/result bundle for the configurable ALU.
// The master drives A/B/Sel and the slave (the ALU) returns the registered Y.
interface cfg_alu_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Sel;
    logic [5:0] Y;

    modport master (output A, output B, output Sel, input Y);
    modport slave  (input A, input B, input Sel, output Y);
endinterface

// File: rtl/cfg_alu.sv
// 4-bit configurable ALU with a registered 6-bit result.
// Only the functional unit picked by Sel sees live operands; the others are held at zero.
module cfg_alu (
    input  logic     clk,
    input  logic     rst,
    cfg_alu_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;
    localparam logic [3:0] OP_XNOR = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_ROL  = 4'hC;
    localparam logic [3:0] OP_INC  = 4'hD;
    localparam logic [3:0] OP_DEC  = 4'hE;
    localparam logic [3:0] OP_CMP  = 4'hF;

    logic [3:0] add_a, add_b, sub_a, sub_b, mul_a, mul_b;
    logic [3:0] lgc_a, lgc_b, sh_a, sh_b, inc_a, dec_a, cmp_a, cmp_b;

    logic [5:0] add_y, sub_y, mul_y, shl_y, shr_y, rol_y, inc_y, dec_y, cmp_y;
    logic [3:0] lgc_y;
    logic [7:0] mul_p;
    logic [7:0] rol_w;
    logic [1:0] sh_amt;

    logic [5:0] y_d, y_q;

    // Operand isolation: every unit's inputs stay at zero unless that unit is selected.
    always_comb begin
        add_a = '0; add_b = '0;
        sub_a = '0; sub_b = '0;
        mul_a = '0; mul_b = '0;
        lgc_a = '0; lgc_b = '0;
        sh_a  = '0; sh_b  = '0;
        inc_a = '0; dec_a = '0;
        cmp_a = '0; cmp_b = '0;
        case (bus.Sel)
            OP_ADD: begin add_a = bus.A; add_b = bus.B; end
            OP_SUB: begin sub_a = bus.A; sub_b = bus.B; end
            OP_MUL: begin mul_a = bus.A; mul_b = bus.B; end
            OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOT: begin
                lgc_a = bus.A;
                lgc_b = bus.B;
            end
            OP_SHL, OP_SHR, OP_ROL: begin sh_a = bus.A; sh_b = bus.B; end
            OP_INC: inc_a = bus.A;
            OP_DEC: dec_a = bus.A;
            OP_CMP: begin cmp_a = bus.A; cmp_b = bus.B; end
            default: ;
        endcase
    end

    assign add_y = {2'b00, add_a} + {2'b00, add_b};
    assign sub_y = {2'b00, sub_a} - {2'b00, sub_b};
    assign mul_p = {4'b0000, mul_a} * {4'b0000, mul_b};
    assign mul_y = (mul_p > 8'd63) ? 6'd63 : mul_p[5:0];

    always_comb begin
        lgc_y = 4'd0;
        case (bus.Sel)
            OP_AND:  lgc_y = lgc_a & lgc_b;
            OP_OR:   lgc_y = lgc_a | lgc_b;
            OP_XOR:  lgc_y = lgc_a ^ lgc_b;
            OP_NAND: lgc_y = ~(lgc_a & lgc_b);
            OP_NOR:  lgc_y = ~(lgc_a | lgc_b);
            OP_XNOR: lgc_y = ~(lgc_a ^ lgc_b);
            OP_NOT:  lgc_y = ~lgc_a;
            default: lgc_y = 4'd0;
        endcase
    end

    // Rotate is done by shifting a doubled copy and keeping the upper nibble.
    assign sh_amt = sh_b[1:0];
    assign shl_y  = {2'b00, sh_a} << sh_amt;
    assign shr_y  = {2'b00, sh_a >> sh_amt};
    assign rol_w  = {sh_a, sh_a} << sh_amt;
    assign rol_y  = {2'b00, rol_w[7:4]};

    assign inc_y = {2'b00, inc_a} + 6'd1;
    assign dec_y = {2'b00, dec_a} - 6'd1;
    assign cmp_y = {3'b000, cmp_a > cmp_b, cmp_a == cmp_b, cmp_a < cmp_b};

    always_comb begin
        y_d = 6'd0;
        case (bus.Sel)
            OP_ADD:  y_d = add_y;
            OP_SUB:  y_d = sub_y;
            OP_MUL:  y_d = mul_y;
            OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOT:
                     y_d = {2'b00, lgc_y};
            OP_SHL:  y_d = shl_y;
            OP_SHR:  y_d = shr_y;
            OP_ROL:  y_d = rol_y;
            OP_INC:  y_d = inc_y;
            OP_DEC:  y_d = dec_y;
            OP_CMP:  y_d = cmp_y;
            default: y_d = 6'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= 6'd0;
        end else begin
            y_q <= y_d;
        end
    end

    assign bus.Y = y_q;
endmodule

// File: tb/tb_cfg_alu.sv
// Self-checking bench for cfg_alu: directed vector table, reset corner cases,
// an opcode sweep and random back-to-back traffic against an arithmetic model.
module tb_cfg_alu;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cfg_alu_if bus ();

    cfg_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic [5:0] exp_y;
    } vec_t;

    vec_t vecs [13];

    // Reference computed with plain integer arithmetic, then cut to 6 bits.
    function automatic logic [5:0] model(input int sel, input int a, input int b);
        int r;
        int s;
        s = b % 4;
        case (sel)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = (a * b > 63) ? 63 : a * b;
            3:  r = (a & b) & 15;
            4:  r = (a | b) & 15;
            5:  r = (a ^ b) & 15;
            6:  r = ~(a & b) & 15;
            7:  r = ~(a | b) & 15;
            8:  r = ~(a ^ b) & 15;
            9:  r = ~a & 15;
            10: r = a * (1 << s);
            11: r = a / (1 << s);
            12: r = ((a * (1 << s)) + (a / (1 << (4 - s)))) & 15;
            13: r = a + 1;
            14: r = a - 1;
            default: r = ((a > b) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a < b) ? 1 : 0);
        endcase
        return 6'(r & 63);
    endfunction

    task automatic applyStimulus(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus.Sel = sel;
        bus.A   = a;
        bus.B   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] exp_y);
        checks++;
        if (bus.Y !== exp_y) begin
            failures++;
            $display("[TB] FAIL %s: Y=%b expected %b", name, bus.Y, exp_y);
        end
    endtask

    initial begin
        logic [3:0] rs, ra, rb;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{4'h0, 4'd15, 4'd15,   6'd30};
        vecs[1]  = '{4'h1, 4'd3,  4'd5,    6'b111110};
        vecs[2]  = '{4'hE, 4'd0,  4'd6,    6'b111111};
        vecs[3]  = '{4'h2, 4'd3,  4'd5,    6'd15};
        vecs[4]  = '{4'h2, 4'd9,  4'd9,    6'd63};
        vecs[5]  = '{4'hA, 4'b1011, 4'd2,  6'b101100};
        vecs[6]  = '{4'hC, 4'b1011, 4'd1,  6'b000111};
        vecs[7]  = '{4'hB, 4'b1000, 4'd3,  6'd1};
        vecs[8]  = '{4'hF, 4'd9,  4'd9,    6'b000010};
        vecs[9]  = '{4'hF, 4'd2,  4'd7,    6'b000001};
        vecs[10] = '{4'hF, 4'd7,  4'd2,    6'b000100};
        vecs[11] = '{4'hD, 4'd15, 4'd0,    6'd16};
        vecs[12] = '{4'hA, 4'b1011, 4'b1110, 6'b101100};

        rst     = 1'b1;
        bus.Sel = 4'h0;
        bus.A   = 4'h0;
        bus.B   = 4'h0;
        #3;
        checkOutput("reset_initial", 6'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(4'h0, 4'd7, 4'd7);
        checkOutput("pre_reset_nonzero", 6'd14);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_between_edges", 6'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold_over_edge", 6'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'h0, 4'd1, 4'd2);
        checkOutput("post_reset_add", 6'd3);

        // Reset pulse between edges discards the pending op; the next edge loads it normally.
        @(negedge clk);
        bus.Sel = 4'h2;
        bus.A   = 4'd3;
        bus.B   = 4'd5;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midop_reset", 6'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("first_edge_after_reset", 6'd15);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d_sel%0h", i, vecs[i].sel), vecs[i].exp_y);
        end

        for (int s = 0; s < 16; s++) begin
            applyStimulus(4'(s), 4'b1011, 4'b0110);
            checkOutput($sformatf("sweep_sel%0h", s), model(s, 11, 6));
        end

        for (int i = 0; i < 40; i++) begin
            rs = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            applyStimulus(rs, ra, rb);
            checkOutput($sformatf("rand%0d_sel%0h_a%0d_b%0d", i, rs, ra, rb),
                        model(int'(rs), int'(ra), int'(rb)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
